// File: rtl/servo_move_sequencer_if.sv
// Requester / observer bundle for the door servo sequencer.
// The master side drives move requests; the slave side is the sequencer.
interface servo_move_sequencer_if #(
  parameter int unsigned PW_W = 20
);
  logic            alarm_req;
  logic [3:0]      alarm_pos;
  logic            alarm_ack;
  logic            key_req;
  logic [3:0]      key_pos;
  logic            key_ack;
  logic            busy;
  logic            done;
  logic            owner;
  logic [PW_W-1:0] pw_cur;
  logic            servo;

  modport master (
    output alarm_req, alarm_pos, key_req, key_pos,
    input  alarm_ack, key_ack, busy, done, owner, pw_cur, servo
  );

  modport slave (
    input  alarm_req, alarm_pos, key_req, key_pos,
    output alarm_ack, key_ack, busy, done, owner, pw_cur, servo
  );
endinterface

// File: rtl/servo_move_sequencer.sv
// Door servo move sequencer: arbitrates alarm (high priority) and keypad
// move requests, slews the pulse width toward the target by a bounded step
// per PWM frame, holds for a settle period, and generates the servo PWM.
module servo_move_sequencer #(
  parameter int unsigned FRAME_CYCLES  = 1_000_000,
  parameter int unsigned PW_MIN        = 20_000,
  parameter int unsigned POS_STEP      = 10_000,
  parameter int unsigned SLEW_STEP     = 2_000,
  parameter int unsigned SETTLE_FRAMES = 25,
  parameter int unsigned PW_W          = 20
) (
  input logic                   clk,
  input logic                   rst,
  servo_move_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StMove   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  localparam logic [PW_W-1:0] FrameLast  = PW_W'(FRAME_CYCLES - 1);
  localparam logic [PW_W-1:0] SlewStep   = PW_W'(SLEW_STEP);
  localparam logic [PW_W-1:0] SettleLast = PW_W'(SETTLE_FRAMES - 1);
  localparam logic [PW_W-1:0] PwMin      = PW_W'(PW_MIN);

  // Index to pulse width; indices above 10 clamp to the 180 degree end stop.
  function automatic logic [PW_W-1:0] pos_to_pw(input logic [3:0] idx);
    logic [3:0] idx_c;
    idx_c = (idx > 4'd10) ? 4'd10 : idx;
    return PW_W'(PW_MIN + POS_STEP * 32'(idx_c));
  endfunction

  logic [1:0]      state_q, state_d;
  logic [PW_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW_W-1:0] pw_cur_q, pw_cur_d;
  logic [PW_W-1:0] pw_tgt_q, pw_tgt_d;
  logic [PW_W-1:0] settle_cnt_q, settle_cnt_d;
  logic            owner_q, owner_d;
  logic            alarm_ack_q, alarm_ack_d;
  logic            key_ack_q, key_ack_d;
  logic            done_q, done_d;
  logic            busy_q;
  logic            servo_q, servo_d;

  logic                   boundary;
  logic                   preempt;
  logic signed [PW_W:0]   diff;
  logic        [PW_W:0]   diff_mag;
  logic                   within_step;

  assign boundary = (frame_cnt_q == FrameLast);
  // Only a keypad-owned move can be taken over, and only by the alarm.
  assign preempt  = (state_q != StIdle) && !owner_q && bus.alarm_req;

  // Signed distance to target and whether the final step lands on it.
  always_comb begin
    diff        = $signed({1'b0, pw_tgt_q}) - $signed({1'b0, pw_cur_q});
    diff_mag    = diff[PW_W] ? -diff : diff;
    within_step = (diff_mag <= {1'b0, SlewStep});
  end

  // Next-state: arbitration, preemption, slewing and settle timing.
  always_comb begin
    state_d      = state_q;
    pw_cur_d     = pw_cur_q;
    pw_tgt_d     = pw_tgt_q;
    settle_cnt_d = settle_cnt_q;
    owner_d      = owner_q;
    alarm_ack_d  = 1'b0;
    key_ack_d    = 1'b0;
    done_d       = 1'b0;
    frame_cnt_d  = boundary ? '0 : frame_cnt_q + 1'b1;
    servo_d      = (frame_cnt_q < pw_cur_q);

    if (preempt) begin
      // Any boundary update this cycle is dropped; new target applies next frame.
      pw_tgt_d     = pos_to_pw(bus.alarm_pos);
      owner_d      = 1'b1;
      alarm_ack_d  = 1'b1;
      settle_cnt_d = '0;
      state_d      = StMove;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.alarm_req) begin
            pw_tgt_d     = pos_to_pw(bus.alarm_pos);
            owner_d      = 1'b1;
            alarm_ack_d  = 1'b1;
            settle_cnt_d = '0;
            state_d      = StMove;
          end else if (bus.key_req) begin
            pw_tgt_d     = pos_to_pw(bus.key_pos);
            owner_d      = 1'b0;
            key_ack_d    = 1'b1;
            settle_cnt_d = '0;
            state_d      = StMove;
          end
        end
        StMove: begin
          if (boundary) begin
            if (within_step) begin
              pw_cur_d     = pw_tgt_q;
              settle_cnt_d = '0;
              state_d      = StSettle;
            end else if (diff[PW_W]) begin
              pw_cur_d = pw_cur_q - SlewStep;
            end else begin
              pw_cur_d = pw_cur_q + SlewStep;
            end
          end
        end
        StSettle: begin
          if (boundary) begin
            if (settle_cnt_q == SettleLast) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_cnt_q  <= '0;
      pw_cur_q     <= PwMin;
      pw_tgt_q     <= PwMin;
      settle_cnt_q <= '0;
      owner_q      <= 1'b0;
      alarm_ack_q  <= 1'b0;
      key_ack_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      servo_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      pw_cur_q     <= pw_cur_d;
      pw_tgt_q     <= pw_tgt_d;
      settle_cnt_q <= settle_cnt_d;
      owner_q      <= owner_d;
      alarm_ack_q  <= alarm_ack_d;
      key_ack_q    <= key_ack_d;
      done_q       <= done_d;
      busy_q       <= (state_d != StIdle);
      servo_q      <= servo_d;
    end
  end

  assign bus.alarm_ack = alarm_ack_q;
  assign bus.key_ack   = key_ack_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.owner     = owner_q;
  assign bus.pw_cur    = pw_cur_q;
  assign bus.servo     = servo_q;

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Bench for servo_move_sequencer with reduced frame/step parameters.
// Expected pulse widths come from a ramp list built with plain arithmetic.
module tb_servo_move_sequencer;

  localparam int FC   = 100;
  localparam int PMIN = 20;
  localparam int PSTP = 10;
  localparam int SLEW = 15;
  localparam int SF   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_move_sequencer_if #(.PW_W(8)) bus ();

  servo_move_sequencer #(
    .FRAME_CYCLES (FC),
    .PW_MIN       (PMIN),
    .POS_STEP     (PSTP),
    .SLEW_STEP    (SLEW),
    .SETTLE_FRAMES(SF),
    .PW_W         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int fc    = 0;   // model frame position after the latest edge
  int m_pw  = 20;  // model pulse width currently applied
  bit exp_servo;

  function automatic int pw_of(input int idx);
    return PMIN + ((idx > 10) ? 10 : idx) * PSTP;
  endfunction

  function automatic int slew_next(input int cur, input int tgt);
    if (tgt > cur) return (cur + SLEW > tgt) ? tgt : cur + SLEW;
    return (cur - SLEW < tgt) ? tgt : cur - SLEW;
  endfunction

  task automatic tick();
    exp_servo = rst ? 1'b0 : (fc < m_pw);
    @(posedge clk);
    #1;
    if (rst) begin
      fc   = 0;
      m_pw = PMIN;
    end else begin
      fc = (fc == FC - 1) ? 0 : fc + 1;
    end
  endtask

  // Idle cycles: PWM keeps running, nothing else moves.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      n_cmp += 3;
      if (bus.servo !== exp_servo) begin
        n_err++; $display("FAIL idle_servo: got %0b expected %0b fc=%0d", bus.servo, exp_servo, fc);
      end
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++; $display("FAIL idle_busy_done: got %0b/%0b expected 0/0", bus.busy, bus.done);
      end
      if (int'(bus.pw_cur) !== m_pw) begin
        n_err++; $display("FAIL idle_pw: got %0d expected %0d", bus.pw_cur, m_pw);
      end
    end
  endtask

  // Checks of the accept cycle (ack visible, first MOVE cycle).
  task automatic check_accept(input bit own);
    n_cmp += 5;
    if (bus.alarm_ack !== own) begin
      n_err++; $display("FAIL accept_alarm_ack: got %0b expected %0b", bus.alarm_ack, own);
    end
    if (bus.key_ack !== !own) begin
      n_err++; $display("FAIL accept_key_ack: got %0b expected %0b", bus.key_ack, !own);
    end
    if (bus.owner !== own || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL accept_owner_busy: got %0b/%0b expected %0b/1", bus.owner, bus.busy, own);
    end
    if (int'(bus.pw_cur) !== m_pw || bus.done !== 1'b0) begin
      n_err++; $display("FAIL accept_pw_done: got %0d/%0b expected %0d/0", bus.pw_cur, bus.done, m_pw);
    end
    if (bus.servo !== exp_servo) begin
      n_err++; $display("FAIL accept_servo: got %0b expected %0b", bus.servo, exp_servo);
    end
  endtask

  // Follows a move from its ack cycle until done, checking every cycle.
  task automatic follow_move(input int tgt, input bit own, input bit keep_key);
    int seq[$];
    int cur, b, n;
    bit exp_done, finished;
    cur = m_pw; b = 0; finished = 0;
    do begin
      cur = slew_next(cur, tgt);
      seq.push_back(cur);
    end while (cur != tgt);
    n = seq.size();
    for (int k = 0; k < (n + SF + 2) * FC && !finished; k++) begin
      tick();
      if (k == 0) begin
        bus.alarm_req = 1'b0;
        if (!keep_key) bus.key_req = 1'b0;
      end
      if (fc == 0) begin
        b++;
        if (b <= n) m_pw = seq[b-1];
      end
      exp_done = (fc == 0) && (b == n + SF);
      n_cmp += 5;
      if (bus.done !== exp_done) begin
        n_err++; $display("FAIL move_done: got %0b expected %0b boundary=%0d", bus.done, exp_done, b);
      end
      if (int'(bus.pw_cur) !== m_pw) begin
        n_err++; $display("FAIL move_pw: got %0d expected %0d fc=%0d", bus.pw_cur, m_pw, fc);
      end
      if (bus.servo !== exp_servo) begin
        n_err++; $display("FAIL move_servo: got %0b expected %0b fc=%0d", bus.servo, exp_servo, fc);
      end
      if (bus.alarm_ack !== 1'b0 || bus.key_ack !== 1'b0) begin
        n_err++; $display("FAIL move_ack: got %0b/%0b expected 0/0", bus.alarm_ack, bus.key_ack);
      end
      if (bus.busy !== !exp_done || bus.owner !== own) begin
        n_err++; $display("FAIL move_busy_owner: got %0b/%0b expected %0b/%0b",
                          bus.busy, bus.owner, !exp_done, own);
      end
      if (exp_done) finished = 1'b1;
    end
    if (!finished) begin
      n_err++; $display("FAIL move_timeout: got no done expected done at boundary %0d", n + SF);
    end
  endtask

  // Runs a keypad move until boundary kb and frame position off, no checks of done.
  task automatic run_partial(input int tgt, input int kb, input int off, output bit reached);
    int cur, b;
    int seq[$];
    cur = m_pw; b = 0; reached = 0;
    do begin
      cur = slew_next(cur, tgt);
      seq.push_back(cur);
    end while (cur != tgt);
    for (int k = 0; k < (kb + 2) * FC && !reached; k++) begin
      tick();
      if (k == 0) bus.key_req = 1'b0;
      if (fc == 0) begin
        b++;
        if (b <= seq.size()) m_pw = seq[b-1];
      end
      n_cmp += 2;
      if (int'(bus.pw_cur) !== m_pw) begin
        n_err++; $display("FAIL partial_pw: got %0d expected %0d", bus.pw_cur, m_pw);
      end
      if (bus.done !== 1'b0) begin
        n_err++; $display("FAIL partial_done: got %0b expected 0", bus.done);
      end
      if (b == kb && fc == off) reached = 1'b1;
    end
    if (!reached) begin
      n_err++; $display("FAIL partial_timeout: got boundary %0d expected %0d", b, kb);
    end
  endtask

  task automatic test_reset();
    int hi;
    rst = 1'b1;
    tick();
    tick();
    n_cmp += 4;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL reset_busy_done: got %0b/%0b expected 0/0", bus.busy, bus.done);
    end
    if (int'(bus.pw_cur) !== PMIN) begin
      n_err++; $display("FAIL reset_pw: got %0d expected %0d", bus.pw_cur, PMIN);
    end
    if (bus.servo !== 1'b0 || bus.owner !== 1'b0) begin
      n_err++; $display("FAIL reset_servo_owner: got %0b/%0b expected 0/0", bus.servo, bus.owner);
    end
    if (bus.alarm_ack !== 1'b0 || bus.key_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_ack: got %0b/%0b expected 0/0", bus.alarm_ack, bus.key_ack);
    end
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      hi = 0;
      for (int k = 0; k < FC; k++) begin
        tick();
        if (bus.servo === 1'b1) hi++;
      end
      n_cmp++;
      if (hi !== PMIN) begin
        n_err++; $display("FAIL idle_frame_high: got %0d expected %0d frame=%0d", hi, PMIN, f);
      end
    end
    idle(5);
  endtask

  task automatic test_key_basic();
    idle($urandom_range(0, 60));
    bus.key_pos = 4'd4;
    bus.key_req = 1'b1;
    tick();
    check_accept(1'b0);
    follow_move(pw_of(4), 1'b0, 1'b0);
  endtask

  task automatic test_both_pending();
    idle($urandom_range(0, 60));
    bus.alarm_pos = 4'd10;
    bus.key_pos   = 4'd0;
    bus.alarm_req = 1'b1;
    bus.key_req   = 1'b1;
    tick();
    check_accept(1'b1);
    follow_move(pw_of(10), 1'b1, 1'b1);
    tick();
    check_accept(1'b0);
    follow_move(pw_of(0), 1'b0, 1'b0);
  endtask

  task automatic test_preempt(input int kb_req, input int off, input int key_idx, input int al_idx);
    int cur, n, kb;
    bit reached;
    cur = m_pw; n = 0;
    do begin
      cur = slew_next(cur, pw_of(key_idx));
      n++;
    end while (cur != pw_of(key_idx));
    kb = (kb_req > n + SF - 1) ? n + SF - 1 : kb_req;
    idle($urandom_range(0, 40));
    bus.key_pos = 4'(key_idx);
    bus.key_req = 1'b1;
    tick();
    check_accept(1'b0);
    run_partial(pw_of(key_idx), kb, off, reached);
    if (reached) begin
      bus.alarm_pos = 4'(al_idx);
      bus.alarm_req = 1'b1;
      tick();
      check_accept(1'b1);
      follow_move(pw_of(al_idx), 1'b1, 1'b0);
    end
  endtask

  task automatic test_random_moves(input int iters);
    bit own;
    int idx;
    for (int i = 0; i < iters; i++) begin
      idle($urandom_range(0, 150));
      own = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      if (own) begin
        bus.alarm_pos = 4'(idx);
        bus.alarm_req = 1'b1;
        bus.key_pos   = 4'($urandom_range(0, 15));
        bus.key_req   = 1'($urandom_range(0, 1));
      end else begin
        bus.key_pos = 4'(idx);
        bus.key_req = 1'b1;
      end
      tick();
      check_accept(own);
      follow_move(pw_of(idx), own, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle($urandom_range(0, 40));
    bus.key_pos = 4'd15;
    bus.key_req = 1'b1;
    tick();
    check_accept(1'b0);
    run_partial(pw_of(15), 3, $urandom_range(1, 98), reached);
    n_cmp++;
    if (int'(bus.pw_cur) !== 65) begin
      n_err++; $display("FAIL mid_pw_before_reset: got %0d expected 65", bus.pw_cur);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 3;
    if (int'(bus.pw_cur) !== PMIN || bus.servo !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_pw_servo: got %0d/%0b expected %0d/0", bus.pw_cur, bus.servo, PMIN);
    end
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_busy_done: got %0b/%0b expected 0/0", bus.busy, bus.done);
    end
    if (bus.owner !== 1'b0 || bus.key_ack !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_owner_ack: got %0b/%0b expected 0/0", bus.owner, bus.key_ack);
    end
    idle(250);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alarm_req = 1'b0;
    bus.alarm_pos = 4'd0;
    bus.key_req   = 1'b0;
    bus.key_pos   = 4'd0;
    test_reset();
    test_key_basic();
    test_both_pending();
    test_preempt(2, 50, 10, 0);
    test_preempt(1, FC - 1, 10, 3);
    test_preempt(2, $urandom_range(1, 99), 2, 13);
    for (int i = 0; i < 3; i++)
      test_preempt($urandom_range(1, 5), $urandom_range(1, 99), $urandom_range(0, 15), $urandom_range(0, 15));
    test_random_moves(6);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
